// File: rtl/irq_controller_pkg.sv
// Shared types and defaults for the external interrupt controller.
// State encodings are fixed because they are visible on debug taps.
package irq_controller_pkg;

   localparam int N_SRC_DEF = 4;
   localparam int ID_W_DEF  = 2;
   localparam int LOST_W_DEF = 8;

   typedef enum logic [1:0] {
      IRQ_IDLE    = 2'd0,
      IRQ_REQ     = 2'd1,
      IRQ_SERVICE = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_controller_if.sv
// Signal bundle between the interrupt controller (slave) and the
// platform/cp0 side (master) that drives sources, mask writes and handshakes.
interface irq_controller_if
   import irq_controller_pkg::*;
#(
   parameter int N_SRC  = N_SRC_DEF,
   parameter int ID_W   = ID_W_DEF,
   parameter int LOST_W = LOST_W_DEF
);
   logic [N_SRC-1:0]  src_in;
   logic              mask_we;
   logic [N_SRC-1:0]  mask_wdata;
   logic              cp0_ir;
   logic              eret;
   logic              ir_req;
   logic [ID_W-1:0]   irq_id;
   logic              irq_active;
   logic [N_SRC-1:0]  pending;
   logic [N_SRC-1:0]  mask;
   logic [LOST_W-1:0] lost_cnt;

   modport master (
      output src_in, mask_we, mask_wdata, cp0_ir, eret,
      input  ir_req, irq_id, irq_active, pending, mask, lost_cnt
   );

   modport slave (
      input  src_in, mask_we, mask_wdata, cp0_ir, eret,
      output ir_req, irq_id, irq_active, pending, mask, lost_cnt
   );
endinterface

// File: rtl/irq_controller_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
   parameter int N_SRC = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_SRC-1:0] req,
   output logic [ID_W-1:0]  id,
   output logic             valid
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      id    = '0;
      valid = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            id    = ID_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// External interrupt controller in front of cp0: edge-detects sources, keeps a
// masked pending set, and feeds one request at a time to cp0 until ERET.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int               N_SRC    = N_SRC_DEF,
   parameter int               ID_W     = ID_W_DEF,
   parameter logic [N_SRC-1:0] MASK_RST = '1,
   parameter int               LOST_W   = LOST_W_DEF
) (
   input logic             clk,
   input logic             rst,
   irq_controller_if.slave bus
);

   irq_state_e        state_q, state_d;
   logic [ID_W-1:0]   irq_id_q, irq_id_d;
   logic [N_SRC-1:0]  pending_q, pending_d;
   logic [N_SRC-1:0]  mask_q, mask_d;
   logic [N_SRC-1:0]  src_prev_q, src_prev_d;
   logic [LOST_W-1:0] lost_cnt_q, lost_cnt_d;

   logic [N_SRC-1:0]  src_edge;
   logic [N_SRC-1:0]  clr;
   logic [N_SRC-1:0]  elig;
   logic [N_SRC-1:0]  elig_req;
   logic [ID_W-1:0]   pick_id;
   logic              pick_valid;

   assign elig = pending_q & mask_q;

   irq_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio_enc (
      .req   (elig),
      .id    (pick_id),
      .valid (pick_valid)
   );

   // A held request is dropped against the mask being written this cycle,
   // so a mask write retracts ir_req on the very next cycle.
   always_comb begin
      src_prev_d = bus.src_in;
      src_edge   = bus.src_in & ~src_prev_q;
      mask_d     = bus.mask_we ? bus.mask_wdata : mask_q;
      elig_req   = pending_q & mask_d;
      clr        = '0;
      state_d    = state_q;
      irq_id_d   = irq_id_q;

      case (state_q)
         IRQ_IDLE: begin
            if (pick_valid) begin
               state_d  = IRQ_REQ;
               irq_id_d = pick_id;
            end
         end
         IRQ_REQ: begin
            if (bus.cp0_ir) begin
               state_d = IRQ_SERVICE;
               clr     = N_SRC'(1) << irq_id_q;
            end else if (!elig_req[irq_id_q]) begin
               state_d = IRQ_IDLE;
            end
         end
         IRQ_SERVICE: begin
            if (bus.eret) begin
               state_d = IRQ_IDLE;
            end
         end
         default: state_d = IRQ_IDLE;
      endcase

      pending_d  = (pending_q & ~clr) | src_edge;
      lost_cnt_d = lost_cnt_q;
      if (((src_edge & pending_q) != '0) && (lost_cnt_q != '1)) begin
         lost_cnt_d = lost_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IRQ_IDLE;
         irq_id_q   <= '0;
         pending_q  <= '0;
         mask_q     <= MASK_RST;
         src_prev_q <= '0;
         lost_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         irq_id_q   <= irq_id_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         src_prev_q <= src_prev_d;
         lost_cnt_q <= lost_cnt_d;
      end
   end

   assign bus.ir_req     = (state_q == IRQ_REQ);
   assign bus.irq_active = (state_q == IRQ_REQ) || (state_q == IRQ_SERVICE);
   assign bus.irq_id     = irq_id_q;
   assign bus.pending    = pending_q;
   assign bus.mask       = mask_q;
   assign bus.lost_cnt   = lost_cnt_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: walks request/service/ERET, priority,
// masking, lost-edge saturation, reset abort and ignored handshakes.
module tb_irq_controller;
   import irq_controller_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   irq_controller_if #(.N_SRC(4), .ID_W(2), .LOST_W(8)) bus ();

   irq_controller #(
      .N_SRC(4), .ID_W(2), .MASK_RST(4'hF), .LOST_W(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are read then too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] src, input logic we,
                                input logic [3:0] wdata, input logic ir,
                                input logic er);
      bus.src_in     = src;
      bus.mask_we    = we;
      bus.mask_wdata = wdata;
      bus.cp0_ir     = ir;
      bus.eret       = er;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic ir_req,
                           input logic [1:0] irq_id, input logic active,
                           input logic [3:0] pending, input logic [3:0] mask,
                           input logic [7:0] lost);
      checkOutput({tag, ".ir_req"}, 32'(bus.ir_req), 32'(ir_req));
      checkOutput({tag, ".irq_id"}, 32'(bus.irq_id), 32'(irq_id));
      checkOutput({tag, ".active"}, 32'(bus.irq_active), 32'(active));
      checkOutput({tag, ".pending"}, 32'(bus.pending), 32'(pending));
      checkOutput({tag, ".mask"}, 32'(bus.mask), 32'(mask));
      checkOutput({tag, ".lost"}, 32'(bus.lost_cnt), 32'(lost));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      tick();
      checkAll("reset", 1'b0, 2'd0, 1'b0, 4'h0, 4'hF, 8'd0);
      rst = 1'b0;
      tick();

      $display("[TB] single source request/service");
      applyStimulus(4'h4, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      checkAll("t1.pend", 1'b0, 2'd0, 1'b0, 4'h4, 4'hF, 8'd0);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      checkAll("t1.req", 1'b1, 2'd2, 1'b1, 4'h4, 4'hF, 8'd0);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
      tick();
      checkAll("t1.svc", 1'b0, 2'd2, 1'b1, 4'h0, 4'hF, 8'd0);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
      tick();
      checkAll("t1.eret", 1'b0, 2'd2, 1'b0, 4'h0, 4'hF, 8'd0);

      $display("[TB] simultaneous sources, priority and ERET gap");
      applyStimulus(4'hA, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      checkOutput("t2.pend", 32'(bus.pending), 32'hA);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      checkAll("t2.req1", 1'b1, 2'd1, 1'b1, 4'hA, 4'hF, 8'd0);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
      tick();
      checkAll("t2.svc1", 1'b0, 2'd1, 1'b1, 4'h8, 4'hF, 8'd0);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
      tick();
      checkOutput("t2.gap", 32'(bus.ir_req), 32'd0);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      checkAll("t2.req3", 1'b1, 2'd3, 1'b1, 4'h8, 4'hF, 8'd0);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
      tick();
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
      tick();
      checkAll("t2.done", 1'b0, 2'd3, 1'b0, 4'h0, 4'hF, 8'd0);

      $display("[TB] masking a held request");
      applyStimulus(4'h1, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      checkAll("t3.req0", 1'b1, 2'd0, 1'b1, 4'h1, 4'hF, 8'd0);
      applyStimulus(4'h0, 1'b1, 4'hE, 1'b0, 1'b0);
      tick();
      checkAll("t3.masked", 1'b0, 2'd0, 1'b0, 4'h1, 4'hE, 8'd0);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      checkOutput("t3.stay_idle", 32'(bus.ir_req), 32'd0);
      applyStimulus(4'h0, 1'b1, 4'hF, 1'b0, 1'b0);
      tick();
      checkOutput("t3.unmask", 32'(bus.mask), 32'hF);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      checkAll("t3.rearm", 1'b1, 2'd0, 1'b1, 4'h1, 4'hF, 8'd0);

      $display("[TB] lost-edge counter saturation");
      applyStimulus(4'h1, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      checkOutput("t4.lost1", 32'(bus.lost_cnt), 32'd1);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      for (int i = 1; i < 300; i++) begin
         applyStimulus(4'h1, 1'b0, 4'h0, 1'b0, 1'b0);
         tick();
         applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
         tick();
      end
      checkAll("t4.sat", 1'b1, 2'd0, 1'b1, 4'h1, 4'hF, 8'd255);
      applyStimulus(4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
      tick();
      checkAll("t4.setwins", 1'b0, 2'd0, 1'b1, 4'h1, 4'hF, 8'd255);

      $display("[TB] cp0_ir ignored in SERVICE");
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
      tick();
      checkAll("t6.ir_svc", 1'b0, 2'd0, 1'b1, 4'h1, 4'hF, 8'd255);

      $display("[TB] reset during SERVICE");
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      checkAll("t5.rst", 1'b0, 2'd0, 1'b0, 4'h0, 4'hF, 8'd0);
      rst = 1'b0;
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
      tick();
      checkAll("t5.eret", 1'b0, 2'd0, 1'b0, 4'h0, 4'hF, 8'd0);

      $display("[TB] eret in IDLE and no preemption in REQ");
      tick();
      checkAll("t6.eret_idle", 1'b0, 2'd0, 1'b0, 4'h0, 4'hF, 8'd0);
      applyStimulus(4'h4, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      checkOutput("t7.req2", 32'(bus.irq_id), 32'd2);
      applyStimulus(4'h1, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      checkAll("t7.hold", 1'b1, 2'd2, 1'b1, 4'h5, 4'hF, 8'd0);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
      tick();
      checkOutput("t7.svc_pend", 32'(bus.pending), 32'h1);
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
      tick();
      applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      checkAll("t7.req0", 1'b1, 2'd0, 1'b1, 4'h1, 4'hF, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
